// File: rtl/sub_result_stage.sv
`default_nettype none
//============================================================================
// Module   : sub_result_stage
// Purpose  : Registered result stage behind the 64-bit SUB datapath: optional
//            saturation, N/Z/C/V flags, 2-entry FIFO, overflow accounting.
// Revision : 1.0 - initial release
//============================================================================
module sub_result_stage #(
   parameter int WIDTH    = 64,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_a_sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_flags,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_sticky
);

   localparam logic [1:0] c_st_empty = 2'd0;
   localparam logic [1:0] c_st_one   = 2'd1;
   localparam logic [1:0] c_st_full  = 2'd2;

   localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_load_head_new;
   logic             w_load_tail;
   logic             w_shift;
   logic [WIDTH-1:0] w_store_data;
   logic [3:0]       w_store_flags;
   logic [WIDTH-1:0] r_head_data;
   logic [3:0]       r_head_flags;
   logic [WIDTH-1:0] r_tail_data;
   logic [3:0]       r_tail_flags;
   logic             r_sticky;
   logic             w_sticky_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_base;
   logic [CNT_W-1:0] w_cnt_nxt;

   // State register: occupancy of the 2-entry buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_empty: begin
            if (w_push) w_state_nxt = c_st_one;
         end
         c_st_one: begin
            if (w_push && !w_pop)      w_state_nxt = c_st_full;
            else if (!w_push && w_pop) w_state_nxt = c_st_empty;
         end
         c_st_full: begin
            if (w_pop) w_state_nxt = c_st_one;
         end
         default: w_state_nxt = c_st_empty;
      endcase
   end

   // Handshake outputs decode the state register only, never out_ready
   always_comb begin
      w_in_ready  = (r_state != c_st_full);
      w_out_valid = (r_state != c_st_empty);
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign w_push    = in_valid && w_in_ready;
   assign w_pop     = w_out_valid && out_ready;

   always_comb begin
      w_load_head_new = w_push && ((r_state == c_st_empty) || ((r_state == c_st_one) && w_pop));
      w_load_tail     = w_push && (r_state == c_st_one) && !w_pop;
      w_shift         = w_pop && (r_state == c_st_full);
   end

   always_comb begin
      w_store_data = in_result;
      if ((SATURATE != 0) && in_overflow) begin
         w_store_data = in_a_sign ? c_sat_min : c_sat_max;
      end
      w_store_flags = {w_store_data[WIDTH-1], (w_store_data == '0), in_carry, in_overflow};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_data  <= '0;
         r_head_flags <= '0;
         r_tail_data  <= '0;
         r_tail_flags <= '0;
      end else begin
         if (w_load_head_new) begin
            r_head_data  <= w_store_data;
            r_head_flags <= w_store_flags;
         end else if (w_shift) begin
            r_head_data  <= r_tail_data;
            r_head_flags <= r_tail_flags;
         end
         if (w_load_tail) begin
            r_tail_data  <= w_store_data;
            r_tail_flags <= w_store_flags;
         end
      end
   end

   assign out_data  = r_head_data;
   assign out_flags = r_head_flags;

   // Clear takes effect before a same-cycle overflow event is counted
   always_comb begin
      w_cnt_base   = clr_sticky ? '0 : r_cnt;
      w_cnt_nxt    = w_cnt_base;
      w_sticky_nxt = r_sticky && !clr_sticky;
      if (w_push && in_overflow) begin
         w_sticky_nxt = 1'b1;
         if (!(&w_cnt_base)) w_cnt_nxt = w_cnt_base + c_cnt_one;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sticky <= w_sticky_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign ovf_sticky = r_sticky;
   assign ovf_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sub_result_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_sub_result_stage
// Purpose  : Self-checking bench; a saturating DUT and a wrapping CNT_W=2 DUT
//            share all inputs and are compared against a queue-based model.
// Revision : 1.0 - initial release
//============================================================================
module tb_sub_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_carry, in_overflow, in_a_sign, out_ready, clr_sticky;
   logic [63:0] in_result;

   logic        in_ready_s, out_valid_s, ovf_sticky_s;
   logic [63:0] out_data_s;
   logic [3:0]  out_flags_s;
   logic [15:0] ovf_count_s;
   logic        in_ready_w, out_valid_w, ovf_sticky_w;
   logic [63:0] out_data_w;
   logic [3:0]  out_flags_w;
   logic [1:0]  ovf_count_w;

   always #5 clk = ~clk;

   sub_result_stage #(.WIDTH(64), .SATURATE(1), .CNT_W(16)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
      .in_a_sign(in_a_sign), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_flags(out_flags_s), .ovf_sticky(ovf_sticky_s),
      .ovf_count(ovf_count_s), .clr_sticky(clr_sticky));

   sub_result_stage #(.WIDTH(64), .SATURATE(0), .CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
      .in_a_sign(in_a_sign), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_flags(out_flags_w), .ovf_sticky(ovf_sticky_w),
      .ovf_count(ovf_count_w), .clr_sticky(clr_sticky));

   typedef struct {
      logic [63:0] data;
      logic [3:0]  flags;
   } entry_t;

   typedef struct {
      logic [63:0] r;
      logic        c, o, a;
      logic [63:0] d_s;
      logic [3:0]  f_s;
      logic [63:0] d_w;
      logic [3:0]  f_w;
      int          cnt;
   } vec_t;

   entry_t q_s[$];
   entry_t q_w[$];
   bit     stk_s, stk_w;
   int     cnt_s, cnt_w;
   int     n_cmp = 0;
   int     n_fail = 0;
   vec_t   tbl[5];

   function automatic entry_t make_entry(bit sat, logic [63:0] r, logic c, logic o, logic a);
      entry_t e;
      if (sat && o) e.data = a ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      else          e.data = r;
      e.flags = {e.data[63], (e.data == 64'd0), c, o};
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("s.in_ready", in_ready_s, q_s.size() != 2);
      check("s.out_valid", out_valid_s, q_s.size() != 0);
      if (q_s.size() != 0) begin
         check("s.out_data", out_data_s, q_s[0].data);
         check("s.out_flags", out_flags_s, q_s[0].flags);
      end
      check("s.sticky", ovf_sticky_s, stk_s);
      check("s.count", ovf_count_s, cnt_s);
      check("w.in_ready", in_ready_w, q_w.size() != 2);
      check("w.out_valid", out_valid_w, q_w.size() != 0);
      if (q_w.size() != 0) begin
         check("w.out_data", out_data_w, q_w[0].data);
         check("w.out_flags", out_flags_w, q_w[0].flags);
      end
      check("w.sticky", ovf_sticky_w, stk_w);
      check("w.count", ovf_count_w, cnt_w);
   endtask

   task automatic model_reset();
      q_s.delete();
      q_w.delete();
      stk_s = 0; stk_w = 0;
      cnt_s = 0; cnt_w = 0;
   endtask

   // One clock: drive, check current state against the model, advance model and DUT
   task automatic cycle(input logic v, input logic [63:0] r, input logic c, input logic o,
                        input logic a, input logic rdy, input logic clr);
      bit push, pop;
      in_valid = v; in_result = r; in_carry = c; in_overflow = o;
      in_a_sign = a; out_ready = rdy; clr_sticky = clr;
      check_model();
      push = v && (q_s.size() != 2);
      pop  = rdy && (q_s.size() != 0);
      if (clr) begin
         stk_s = 0; stk_w = 0; cnt_s = 0; cnt_w = 0;
      end
      if (push && o) begin
         stk_s = 1; stk_w = 1;
         if (cnt_s < 65535) cnt_s++;
         if (cnt_w < 3)     cnt_w++;
      end
      if (pop) begin
         q_s.delete(0);
         q_w.delete(0);
      end
      if (push) begin
         q_s.push_back(make_entry(1'b1, r, c, o, a));
         q_w.push_back(make_entry(1'b0, r, c, o, a));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{64'd5, 1'b1, 1'b0, 1'b0, 64'd5, 4'b0010, 64'd5, 4'b0010, 0};
      tbl[1] = '{64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0100, 64'd0, 4'b0100, 0};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 0};
      tbl[3] = '{64'h8000_0000_0000_0005, 1'b0, 1'b1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001, 64'h8000_0000_0000_0005, 4'b1001, 1};
      tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFB, 1'b1, 1'b1, 1'b1,
                 64'h8000_0000_0000_0000, 4'b1011, 64'h7FFF_FFFF_FFFF_FFFB, 4'b0011, 2};

      rst_n = 1'b0;
      in_valid = 0; in_result = '0; in_carry = 0; in_overflow = 0;
      in_a_sign = 0; out_ready = 0; clr_sticky = 0;
      model_reset();
      #12;
      check("reset.out_valid", out_valid_s, 1'b0);
      check("reset.in_ready", in_ready_s, 1'b1);
      check("reset.out_data", out_data_s, 64'd0);
      check("reset.out_flags", out_flags_s, 4'd0);
      check("reset.sticky", ovf_sticky_s, 1'b0);
      check("reset.count", ovf_count_s, 16'd0);
      #8 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table vectors: push into empty stage, check next cycle, then pop
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].a, 1'b0, 1'b0);
         check("tbl.out_valid", out_valid_s, 1'b1);
         check("tbl.s_data", out_data_s, tbl[i].d_s);
         check("tbl.s_flags", out_flags_s, tbl[i].f_s);
         check("tbl.w_data", out_data_w, tbl[i].d_w);
         check("tbl.w_flags", out_flags_w, tbl[i].f_w);
         check("tbl.count", ovf_count_s, tbl[i].cnt);
         check("tbl.sticky", ovf_sticky_s, tbl[i].cnt != 0);
         cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("tbl.drained", out_valid_s, 1'b0);

      // Backpressure: fill, ignored third offer, drain in order
      cycle(1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("full.in_ready", in_ready_s, 1'b0);
      cycle(1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("full.hold_data", out_data_s, 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("full.second", out_data_s, 64'd2);
      check("full.in_ready_back", in_ready_s, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("full.empty", out_valid_s, 1'b0);

      // Push+pop at occupancy one keeps one entry, newest at head
      cycle(1'b1, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pp.data", out_data_s, 64'd11);
      check("pp.in_ready", in_ready_s, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pp.empty", out_valid_s, 1'b0);

      // Counter saturation on the CNT_W=2 instance
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("cnt2.sat", ovf_count_w, 2'd3);
      check("cnt16.five", ovf_count_s, 16'd5);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Clear coincident with an overflow push
      cycle(1'b1, 64'h42, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      check("clr.sticky", ovf_sticky_s, 1'b1);
      check("clr.count_s", ovf_count_s, 16'd1);
      check("clr.count_w", ovf_count_w, 2'd1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset while full
      cycle(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst.full", in_ready_s, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst.out_valid", out_valid_s, 1'b0);
      check("rst.in_ready", in_ready_s, 1'b1);
      check("rst.out_data", out_data_s, 64'd0);
      check("rst.out_flags", out_flags_s, 4'd0);
      check("rst.count_w", ovf_count_w, 2'd0);
      model_reset();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 4) != 0, {$urandom, $urandom}, $urandom % 2,
               ($urandom % 4) == 0, $urandom % 2, ($urandom % 3) != 0,
               ($urandom % 50) == 0);
      end
      check_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
